sequential_divider: RTL and testbench



---
 rtl/divider_pkg.sv | 23 ++
 rtl/divider_restoring_step.sv | 37 +++
 rtl/sequential_divider.sv | 134 +++++++++++++
 tb/tb_sequential_divider.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// -----------------------------------------------------------------------------
// divider_pkg
// Shared definitions for the sequential restoring divider:
//   - state_t       : FSM state encoding (IDLE / RUN / FINISH)
//   - DEFAULT_WIDTH : default operand width
//   - cnt_width()   : width of the iteration counter, clog2(width + 1)
// -----------------------------------------------------------------------------
package divider_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    // The counter must be able to hold the value WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/divider_restoring_step.sv
// -----------------------------------------------------------------------------
// divider_restoring_step
// One purely combinational restoring-division step. Shifts the next dividend
// bit into the partial remainder, trial-subtracts the divisor and keeps the
// difference only when it does not go negative.
//
// Ports:
//   partial_rem  in   WIDTH  partial remainder from the previous step (< divisor)
//   in_bit       in   1      next dividend bit, MSB first
//   divisor      in   WIDTH  unsigned divisor
//   next_rem     out  WIDTH  updated partial remainder
//   q_bit        out  1      quotient bit produced by this step
// -----------------------------------------------------------------------------
module divider_restoring_step
    import divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] partial_rem,
    input  logic             in_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // One extra bit keeps both the shifted value and the difference exact.
    assign shifted = {partial_rem, in_bit};
    assign trial   = shifted - {1'b0, divisor};

    // Since partial_rem < divisor, whichever value is kept fits in WIDTH bits.
    assign q_bit    = ~trial[WIDTH];
    assign next_rem = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/sequential_divider.sv
// -----------------------------------------------------------------------------
// sequential_divider
// Multi-cycle unsigned restoring divider producing one quotient bit per clock.
// An accepted start captures the operands; WIDTH RUN cycles follow, then a
// single FINISH cycle with done=1. A zero divisor skips RUN and reports
// quotient = all ones, remainder = dividend, div_by_zero = 1.
//
// Ports:
//   clk          in   1      system clock, rising edge
//   rst_n        in   1      asynchronous active-low reset
//   start        in   1      request, sampled only while busy = 0
//   dividend     in   WIDTH  unsigned numerator, captured on accepted start
//   divisor      in   WIDTH  unsigned denominator, captured on accepted start
//   busy         out  1      high in RUN and FINISH
//   done         out  1      one-cycle pulse, results valid in this cycle
//   quotient     out  WIDTH  result, held until the next completed operation
//   remainder    out  WIDTH  result, held until the next completed operation
//   div_by_zero  out  1      zero-divisor flag of the last completed operation
// -----------------------------------------------------------------------------
module sequential_divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_q;     // partial remainder
    logic [WIDTH-1:0] quo_q;     // dividend bits shift out the top, quotient bits in at the bottom
    logic [WIDTH-1:0] div_q;     // captured divisor
    logic [WIDTH-1:0] step_rem;
    logic             step_qbit;
    logic             last_step;

    divider_restoring_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .partial_rem (rem_q),
        .in_bit      (quo_q[WIDTH-1]),
        .divisor     (div_q),
        .next_rem    (step_rem),
        .q_bit       (step_qbit)
    );

    assign last_step = (cnt == CNT_W'(1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (divisor == '0) ? FINISH : RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_nxt = FINISH;
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Working registers and result registers. Results are written on the edge
    // that enters FINISH so they are already valid while done is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        div_q <= divisor;
                        quo_q <= dividend;
                        rem_q <= '0;
                        cnt   <= CNT_W'(WIDTH);
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    rem_q <= step_rem;
                    quo_q <= {quo_q[WIDTH-2:0], step_qbit};
                    cnt   <= cnt - CNT_W'(1);
                    if (last_step) begin
                        quotient    <= {quo_q[WIDTH-2:0], step_qbit};
                        remainder   <= step_rem;
                        div_by_zero <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == FINISH);

endmodule

// File: tb/tb_sequential_divider.sv
// -----------------------------------------------------------------------------
// tb_sequential_divider
// Directed and random self-checking bench for sequential_divider, WIDTH = 8.
// -----------------------------------------------------------------------------
module tb_sequential_divider;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks;
    int errors;
    int cyc;

    sequential_divider #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Issue one operation from an IDLE cycle and wait (bounded) for done.
    // Returns in the done cycle, 1 time unit after the edge. The operand
    // inputs are scrambled after acceptance.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int busy_cyc,
                          output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic z, output int done_at, output bit timed_out);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        lat       = 1;
        busy_cyc  = 0;
        timed_out = 1'b0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_cyc++;
            @(posedge clk); #1;
            lat++;
        end
        if (done !== 1'b1) timed_out = 1'b1;
        else if (busy === 1'b1) busy_cyc++;
        q       = quotient;
        r       = remainder;
        z       = div_by_zero;
        done_at = cyc;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
            errors++;
            $display("FAIL reset_values got busy=%b done=%b dbz=%b q=%0d r=%0d required all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat, bc, dat;
        logic [W-1:0] q, r;
        logic z;
        bit to;
        run_op(8'd100, 8'd7, lat, bc, q, r, z, dat, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL basic_timeout got no done within %0d cycles required done", lat);
        end
        checks++;
        if (lat != 9) begin
            errors++;
            $display("FAIL basic_latency got %0d required 9", lat);
        end
        checks++;
        if (bc != 9) begin
            errors++;
            $display("FAIL basic_busy_cycles got %0d required 9", bc);
        end
        checks++;
        if ({q, r, z} !== {8'd14, 8'd2, 1'b0}) begin
            errors++;
            $display("FAIL basic_100_7 got q=%0d r=%0d z=%b required q=14 r=2 z=0", q, r, z);
        end
        @(posedge clk); #1;
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL basic_done_pulse got done=%b busy=%b required 0 0", done, busy);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({quotient, remainder, div_by_zero} !== {8'd14, 8'd2, 1'b0}) begin
            errors++;
            $display("FAIL basic_hold got q=%0d r=%0d z=%b required q=14 r=2 z=0",
                     quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_div_zero();
        int lat, bc, dat;
        logic [W-1:0] q, r;
        logic z;
        bit to;
        run_op(8'd37, 8'd0, lat, bc, q, r, z, dat, to);
        checks++;
        if (to || lat > 2) begin
            errors++;
            $display("FAIL div0_latency got %0d cycles required at most 2", lat);
        end
        checks++;
        if ({q, r, z} !== {8'd255, 8'd37, 1'b1}) begin
            errors++;
            $display("FAIL div0_37_0 got q=%0d r=%0d z=%b required q=255 r=37 z=1", q, r, z);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_boundaries();
        logic [W-1:0] va [3] = '{8'd5, 8'd255, 8'd255};
        logic [W-1:0] vb [3] = '{8'd9, 8'd1, 8'd255};
        logic [W-1:0] eq [3] = '{8'd0, 8'd255, 8'd1};
        logic [W-1:0] er [3] = '{8'd5, 8'd0, 8'd0};
        int lat, bc, dat;
        logic [W-1:0] q, r;
        logic z;
        bit to;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], lat, bc, q, r, z, dat, to);
            checks++;
            if (to || {q, r, z} !== {eq[i], er[i], 1'b0}) begin
                errors++;
                $display("FAIL boundary_%0d_%0d got q=%0d r=%0d z=%b timeout=%0d required q=%0d r=%0d z=0",
                         va[i], vb[i], q, r, z, to, eq[i], er[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 8'd3;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < 40) begin
            if (lat == 2 || lat == 4) begin
                start    = 1'b1;
                dividend = 8'd9;
                divisor  = 8'd2;
            end
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
        end
        checks++;
        if (done !== 1'b1 || lat != 9) begin
            errors++;
            $display("FAIL ignore_latency got %0d done=%b required 9", lat, done);
        end
        checks++;
        if ({quotient, remainder, div_by_zero} !== {8'd66, 8'd2, 1'b0}) begin
            errors++;
            $display("FAIL ignore_200_3 got q=%0d r=%0d z=%b required q=66 r=2 z=0",
                     quotient, remainder, div_by_zero);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_no_restart got busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bc, dat;
        logic [W-1:0] q, r;
        logic z;
        bit to;
        bit saw_done;
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 8'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
            errors++;
            $display("FAIL midreset_async got busy=%b done=%b dbz=%b q=%0d r=%0d required all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL midreset_no_done got activity after reset required none");
        end
        run_op(8'd50, 8'd6, lat, bc, q, r, z, dat, to);
        checks++;
        if (to || {q, r, z} !== {8'd8, 8'd2, 1'b0}) begin
            errors++;
            $display("FAIL midreset_50_6 got q=%0d r=%0d z=%b timeout=%0d required q=8 r=2 z=0",
                     q, r, z, to);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int lat, bc, d1, d2;
        logic [W-1:0] q, r;
        logic z;
        bit to1, to2;
        run_op(8'd81, 8'd9, lat, bc, q, r, z, d1, to1);
        checks++;
        if (to1 || {q, r, z} !== {8'd9, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL b2b_81_9 got q=%0d r=%0d z=%b required q=9 r=0 z=0", q, r, z);
        end
        @(posedge clk); #1;
        run_op(8'd80, 8'd9, lat, bc, q, r, z, d2, to2);
        checks++;
        if (to2 || {q, r, z} !== {8'd8, 8'd8, 1'b0}) begin
            errors++;
            $display("FAIL b2b_80_9 got q=%0d r=%0d z=%b required q=8 r=8 z=0", q, r, z);
        end
        checks++;
        if (d2 - d1 != 10) begin
            errors++;
            $display("FAIL b2b_spacing got %0d cycles required 10", d2 - d1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int lat, bc, dat;
        logic [W-1:0] a, b, q, r, xq, xr;
        logic z, xz;
        bit to;
        for (int i = 0; i < 1000; i++) begin
            a = W'($urandom_range(0, 255));
            b = W'($urandom_range(0, 255));
            if (b == '0) begin
                xq = '1;
                xr = a;
                xz = 1'b1;
            end else begin
                xq = a / b;
                xr = a % b;
                xz = 1'b0;
            end
            run_op(a, b, lat, bc, q, r, z, dat, to);
            checks++;
            if (to || {q, r, z} !== {xq, xr, xz}) begin
                errors++;
                $display("FAIL random_%0d_%0d got q=%0d r=%0d z=%b timeout=%0d required q=%0d r=%0d z=%b",
                         a, b, q, r, z, to, xq, xr, xz);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_div_zero();
        test_boundaries();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
